// File: rtl/mem_access_ctrl.sv
// Fetch/load-store arbiter and sequencer for the shared 64-bit byte-banked data memory; narrow stores are read-modify-write.
// Optional feature macro MEMCTRL_MISALIGN_TRAP_EN refuses misaligned accesses and adds the if_err output.
module mem_access_ctrl #(
  parameter int ADDR_W = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
`ifdef MEMCTRL_MISALIGN_TRAP_EN
  output logic              if_err,
`endif
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_done,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [63:0]       mem_wdata,
  output logic              mem_wr,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RW, S_WR, S_DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, uns_q, port_q, last_d_q;
  logic [1:0]        size_q;
  logic [63:0]       wdata_q, rbuf_q;

  logic              req_any, grant_d, refused;
  logic [ADDR_W-1:0] addr_d;
  logic [1:0]        size_d;
  logic [7:0]        lane_mask;
  logic [63:0]       ext_data;

  // On a tie data wins unless data was the port served last.
  assign req_any = if_req | d_req;
  assign grant_d = d_req & (~if_req | ~last_d_q);
  assign addr_d  = grant_d ? d_addr : if_addr;
  assign size_d  = grant_d ? d_size : 2'b10;

`ifdef MEMCTRL_MISALIGN_TRAP_EN
  logic       err_q, trap_d;
  logic [2:0] align_mask;
  always_comb begin
    case (size_d)
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end
  assign trap_d  = |(addr_d[2:0] & align_mask);
  assign refused = err_q;
  assign d_err   = d_done & err_q;
  assign if_err  = if_done & err_q;
`else
  assign refused = 1'b0;
  assign d_err   = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      port_q   <= 1'b0;
      last_d_q <= 1'b0;
      size_q   <= 2'b00;
      wdata_q  <= '0;
      rbuf_q   <= '0;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            port_q  <= grant_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= grant_d & d_we;
            uns_q   <= ~grant_d | d_unsigned;
            wdata_q <= d_wdata;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
            err_q   <= trap_d;
            if (trap_d) state_q <= S_DONE;
            else
`endif
            if (grant_d && d_we && d_size == 2'b11) state_q <= S_WR;
            else state_q <= S_RD;
          end
        end
        S_RD: state_q <= S_RW;
        S_RW: begin
          rbuf_q  <= mem_rdata;
          state_q <= we_q ? S_WR : S_DONE;
        end
        S_WR: state_q <= S_DONE;
        S_DONE: begin
          last_d_q <= port_q;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
          err_q    <= 1'b0;
`endif
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_wr    = (state_q == S_WR) & ~Reset;
  assign if_done   = (state_q == S_DONE) & ~port_q;
  assign d_done    = (state_q == S_DONE) & port_q;
  assign if_rdata  = (if_done & ~refused) ? rbuf_q[31:0] : 32'h0;
  assign d_rdata   = (d_done & ~refused) ? ext_data : 64'h0;

  // Store lanes come from wdata_q; the rest are written back from the read buffer.
  always_comb begin
    case (size_q)
      2'b00:   lane_mask = 8'h01;
      2'b01:   lane_mask = 8'h03;
      2'b10:   lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
    for (int k = 0; k < 8; k++)
      mem_wdata[8*k +: 8] = lane_mask[k] ? wdata_q[8*k +: 8] : rbuf_q[8*k +: 8];
  end

  always_comb begin
    case (size_q)
      2'b00:   ext_data = {{56{~uns_q & rbuf_q[7]}},  rbuf_q[7:0]};
      2'b01:   ext_data = {{48{~uns_q & rbuf_q[15]}}, rbuf_q[15:0]};
      2'b10:   ext_data = {{32{~uns_q & rbuf_q[31]}}, rbuf_q[31:0]};
      default: ext_data = rbuf_q;
    endcase
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller and two-port arbiter in front of the 64-bit byte-banked data memory. Shares the single memory between the instruction-fetch port (32-bit reads) and the load/store port (byte/half/word/doubleword, signed or unsigned). Sub-doubleword stores are performed as read-modify-write, because the memory's single write enable always writes all 8 byte lanes. Sits between the CPU control unit and the memory; it is the only block that drives the memory's address, data and write-enable pins.

## Interface
- `ADDR_W`, default 64: address width of both ports and of the memory.
- `Clk` in 1: system clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request. Level signal, held until `if_done`.
- `if_addr` in ADDR_W: fetch byte address.
- `if_done` out 1: one-cycle pulse; `if_rdata` is valid in the same cycle.
- `if_rdata` out 32: fetched word, equal to bytes addr..addr+3 in little-endian order.
- `d_req` in 1: data request. Level signal, held until `d_done`.
- `d_we` in 1: 1 selects a store, 0 selects a load.
- `d_size` in 2: 00 byte, 01 half, 10 word, 11 doubleword.
- `d_unsigned` in 1: 1 selects zero-extension of load data, 0 selects sign-extension.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in 64: store data. The low `size` bytes are used.
- `d_done` out 1: one-cycle pulse marking completion of a load or store.
- `d_rdata` out 64: extended load data, valid while `d_done` is high.
- `d_err` out 1: high together with `d_done` when an access is refused (see Configuration).
- `mem_raddr` out ADDR_W: memory read address.
- `mem_waddr` out ADDR_W: memory write address.
- `mem_wdata` out 64: memory write data.
- `mem_wr` out 1: memory write enable.
- `mem_rdata` in 64: memory read data. It is valid one cycle after `mem_raddr` is sampled.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: arbitrate between requests.
  - RD: memory samples `mem_raddr`.
  - RW: `mem_rdata` is valid and is captured.
  - WR: `mem_wr`=1.
  - DONE: done pulse.
- IDLE arbitration:
  - If only one request is high, that request wins.
  - If both are high, round-robin on the `last_d` flag: the port not served last wins.
  - `last_d` resets to 0, so fetch is treated as last-served-not and data wins the first tie.
- On grant, latch the request into `addr_q`, `we_q`, `size_q`, `uns_q`, `wdata_q` and `port_q`.
- `mem_raddr` and `mem_waddr` both equal `addr_q` in every state.
- Loads and fetches follow IDLE→RD→RW→DONE.
  - In RW, capture `mem_rdata` into `rbuf`.
  - In DONE, drive `if_rdata`=`rbuf[31:0]`, or `d_rdata`=`rbuf[8·2^size−1:0]` extended per `uns_q`.
- Doubleword stores follow IDLE→WR→DONE, with `mem_wdata`=`wdata_q`.
- Sub-doubleword stores follow IDLE→RD→RW→WR→DONE.
  - `mem_wdata` takes byte k from `wdata_q` for k < 2^size and from `rbuf` otherwise.
- DONE pulses the done signal of `port_q` and returns to IDLE.
  - `last_d` is set to `port_q`=data.
  - A request that is still high in IDLE is treated as a new transaction.
- Requests are not sampled outside IDLE. Input changes during a transaction are ignored.
- Address arithmetic is modulo 2^ADDR_W. The memory itself wraps at its 16-bit bank index; no special handling is needed here.

## Timing
- Reset values:
  - state IDLE, `last_d`=0.
  - `if_done`, `d_done`, `d_err`, `mem_wr`, `busy` all 0.
  - `if_rdata`, `d_rdata`, `mem_wdata`, `mem_raddr`, `mem_waddr` all 0.
- Latency, counted from the accept edge to the done pulse:
  - Load or fetch: done in the 4th cycle (accept, RD, RW, DONE).
  - Doubleword store: done in the 3rd cycle.
  - Sub-doubleword store: done in the 5th cycle.
- Throughput: IDLE occupies one cycle between transactions, so back-to-back transactions are accepted on the cycle after DONE.
- `mem_wr` is combinational from state WR and gated by `!Reset`. Reset asserted during WR therefore suppresses the write.
- Reset mid-transaction:
  - The transaction is abandoned and no done pulse is issued.
  - The requester re-issues it after reset.
- Simultaneous requests: only the winner gets a done pulse. The loser stays pending and wins the next IDLE, because round-robin prevents starvation.

## Configuration
- Macro: `MEMCTRL_MISALIGN_TRAP_EN`.
- When defined:
  - An access is refused if `addr mod 2^size` ≠ 0 (fetch uses size 10).
  - The refused access goes IDLE→DONE with `d_err`=1 and `rdata`=0.
  - Memory is never touched and `mem_wr` stays 0.
  - A misaligned fetch also raises `d_err`=0 but `if_done` with `if_rdata`=0.
  - An error output `if_err` is added, pulsed with `if_done`.
- When undefined:
  - Misaligned accesses proceed normally, since the byte-banked memory handles any alignment.
  - `d_err` is tied to 0 and `if_err` is absent.

## Test plan
- Reset, then memory is preloaded at 0x10 with 0x8877665544332211. Fetch at 0x10 → `if_done` on the 4th cycle, `if_rdata`=0x44332211.
- Signed byte load at 0x17, where the byte is 0x88 → `d_rdata`=0xFFFFFFFFFFFFFF88. Unsigned byte load at the same address → 0x0000000000000088.
- Half store 0xBEEF at 0x10, then doubleword load at 0x10 → 0x887766554433BEEF. `mem_wr` is high exactly one cycle and the done pulse arrives on the 5th cycle.
- `if_req` and `d_req` rise together and both stay high:
  - Grant order is data, fetch, data, fetch.
  - Each done pulse comes exactly once per grant.
- Reset asserted during a store's WR cycle → memory is unchanged, no `d_done`, all outputs read 0 the next cycle.
- With `MEMCTRL_MISALIGN_TRAP_EN`, a word load at 0x11 → `d_done` and `d_err` on the 2nd cycle, `d_rdata`=0, `mem_wr` never asserted. Without the macro, the same load → 0x55443322.
